// File: rtl/ahb_mbox_ctrl.sv
// Mailbox handshake controller: two one-way channels (CH0 A->B, CH1 B->A)
// with POST/ACK/CLR sequencing, per-message timeout and agent interrupts.
module ahb_mbox_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TMO_W      = 16
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic                  hsel,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [DATA_WIDTH-1:0] hwdata,
   output logic [1:0]            hresp,
   output logic                  hready,
   output logic [DATA_WIDTH-1:0] hrdata,
   output logic                  intr_a,
   output logic                  intr_b
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FULL  = 2'd1,
      ST_ACKED = 2'd2
   } ch_state_t;

   // Register offset within one channel's 16-byte window
   function automatic logic [7:0] ch_addr(input logic ch, input logic [3:0] off);
      return {3'b000, ch, off};
   endfunction

   function automatic logic [DATA_WIDTH-1:0] stat_word(
      input logic rx, input logic full, input logic ack, input logic err,
      input logic tmo, input logic [14:0] size, input logic [7:0] id);
      return DATA_WIDTH'({rx, full, ack, err, tmo, 4'b0000, size, id});
   endfunction

   logic                  r_wr_en;
   logic [7:0]            r_waddr;
   logic [DATA_WIDTH-1:0] r_hrdata;
   logic                  r_intr_a;
   logic                  r_intr_b;
   logic [TMO_W-1:0]      r_lim;

   ch_state_t        r_state     [2];
   ch_state_t        w_state_nxt [2];
   logic [1:0]       r_rx, r_ack, r_err, r_tmo;
   logic [1:0]       w_rx_nxt, w_ack_nxt, w_err_nxt, w_tmo_nxt;
   logic [14:0]      r_size      [2];
   logic [14:0]      w_size_nxt  [2];
   logic [7:0]       r_id        [2];
   logic [7:0]       w_id_nxt    [2];
   logic [TMO_W-1:0] r_cnt       [2];
   logic [TMO_W-1:0] w_cnt_nxt   [2];
   logic [TMO_W:0]   w_cnt_p1    [2];
   logic [1:0]       w_post, w_ack, w_clr, w_clr0, w_fire, w_err_set;

   logic                  w_rd_valid;
   logic                  w_wr_valid;
   logic                  w_lim_wr;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_unused;

   assign w_rd_valid = hsel & htrans[1] & ~hwrite;
   assign w_wr_valid = hsel & htrans[1] & hwrite;
   assign w_lim_wr   = r_wr_en && (r_waddr == 8'h20);
   assign w_unused   = ^{haddr, htrans[0], hwdata};

   assign hresp  = 2'b00;
   assign hready = 1'b1;
   assign hrdata = r_hrdata;
   assign intr_a = r_intr_a;
   assign intr_b = r_intr_b;

   // Read mux, decoded from the address phase
   always_comb begin
      w_rdata = {DATA_WIDTH{1'b0}};
      case (haddr[7:0])
         8'h04:   w_rdata = stat_word(r_rx[0], r_state[0] == ST_FULL, r_ack[0],
                                      r_err[0], r_tmo[0], r_size[0], r_id[0]);
         8'h14:   w_rdata = stat_word(r_rx[1], r_state[1] == ST_FULL, r_ack[1],
                                      r_err[1], r_tmo[1], r_size[1], r_id[1]);
         8'h20:   w_rdata = DATA_WIDTH'(r_lim);
         default: w_rdata = {DATA_WIDTH{1'b0}};
      endcase
   end

   // Channel next-state, flags, descriptor and timeout counter
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         w_state_nxt[c] = r_state[c];
         w_rx_nxt[c]    = r_rx[c];
         w_ack_nxt[c]   = r_ack[c];
         w_size_nxt[c]  = r_size[c];
         w_id_nxt[c]    = r_id[c];
         w_post[c]      = r_wr_en && (r_waddr == ch_addr(c[0], 4'h0));
         w_ack[c]       = r_wr_en && (r_waddr == ch_addr(c[0], 4'h8));
         w_clr[c]       = r_wr_en && (r_waddr == ch_addr(c[0], 4'hC));
         w_clr0[c]      = w_clr[c] && hwdata[0];
         w_cnt_p1[c]    = {1'b0, r_cnt[c]} + {{TMO_W{1'b0}}, 1'b1};
         // ACK written in the would-be firing cycle pre-empts the timeout
         w_fire[c]      = (r_state[c] == ST_FULL) && (r_lim != {TMO_W{1'b0}}) &&
                          (w_cnt_p1[c] >= {1'b0, r_lim}) && !w_ack[c];
         w_err_set[c]   = (w_post[c] && (r_state[c] != ST_IDLE)) ||
                          (w_ack[c]  && (r_state[c] != ST_FULL)) ||
                          (w_clr0[c] && (r_state[c] == ST_FULL));
         if ((r_state[c] == ST_FULL) && (r_lim != {TMO_W{1'b0}}) &&
             (r_cnt[c] != {TMO_W{1'b1}})) begin
            w_cnt_nxt[c] = w_cnt_p1[c][TMO_W-1:0];
         end else begin
            w_cnt_nxt[c] = r_cnt[c];
         end
         case (r_state[c])
            ST_IDLE: begin
               if (w_post[c]) begin
                  w_state_nxt[c] = ST_FULL;
                  w_size_nxt[c]  = hwdata[22:8];
                  w_id_nxt[c]    = hwdata[7:0];
                  w_rx_nxt[c]    = 1'b1;
                  w_cnt_nxt[c]   = {TMO_W{1'b0}};
               end else if (w_clr0[c]) begin
                  w_ack_nxt[c]   = 1'b0;
               end else begin
                  w_state_nxt[c] = ST_IDLE;
               end
            end
            ST_FULL: begin
               if (w_ack[c]) begin
                  w_state_nxt[c] = ST_ACKED;
                  w_rx_nxt[c]    = 1'b0;
                  w_ack_nxt[c]   = 1'b1;
               end else if (w_fire[c]) begin
                  w_state_nxt[c] = ST_IDLE;
                  w_rx_nxt[c]    = 1'b0;
                  w_ack_nxt[c]   = 1'b1;
               end else begin
                  w_state_nxt[c] = ST_FULL;
               end
            end
            ST_ACKED: begin
               if (w_clr0[c]) begin
                  w_state_nxt[c] = ST_IDLE;
                  w_ack_nxt[c]   = 1'b0;
               end else begin
                  w_state_nxt[c] = ST_ACKED;
               end
            end
            default: w_state_nxt[c] = ST_IDLE;
         endcase
         // Set wins over a same-cycle clear
         if (w_err_set[c]) begin
            w_err_nxt[c] = 1'b1;
         end else if (w_clr[c] && hwdata[1]) begin
            w_err_nxt[c] = 1'b0;
         end else begin
            w_err_nxt[c] = r_err[c];
         end
         if (w_fire[c]) begin
            w_tmo_nxt[c] = 1'b1;
         end else if (w_clr[c] && hwdata[2]) begin
            w_tmo_nxt[c] = 1'b0;
         end else begin
            w_tmo_nxt[c] = r_tmo[c];
         end
      end
   end

   // Bus pipeline, read data, limit register and interrupt outputs
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_wr_en  <= 1'b0;
         r_waddr  <= 8'h00;
         r_hrdata <= {DATA_WIDTH{1'b0}};
         r_lim    <= {TMO_W{1'b0}};
         r_intr_a <= 1'b0;
         r_intr_b <= 1'b0;
      end else begin
         r_wr_en  <= w_wr_valid;
         r_waddr  <= haddr[7:0];
         if (w_rd_valid) begin
            r_hrdata <= w_rdata;
         end
         if (w_lim_wr) begin
            r_lim <= hwdata[TMO_W-1:0];
         end
         r_intr_b <= r_rx[0] | r_ack[1];
         r_intr_a <= r_rx[1] | r_ack[0];
      end
   end

   // Channel state registers
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_rx  <= 2'b00;
         r_ack <= 2'b00;
         r_err <= 2'b00;
         r_tmo <= 2'b00;
         for (int c = 0; c < 2; c++) begin
            r_state[c] <= ST_IDLE;
            r_size[c]  <= 15'd0;
            r_id[c]    <= 8'd0;
            r_cnt[c]   <= {TMO_W{1'b0}};
         end
      end else begin
         r_rx  <= w_rx_nxt;
         r_ack <= w_ack_nxt;
         r_err <= w_err_nxt;
         r_tmo <= w_tmo_nxt;
         for (int c = 0; c < 2; c++) begin
            r_state[c] <= w_state_nxt[c];
            r_size[c]  <= w_size_nxt[c];
            r_id[c]    <= w_id_nxt[c];
            r_cnt[c]   <= w_cnt_nxt[c];
         end
      end
   end

endmodule

// File: tb/tb_ahb_mbox_ctrl.sv
// Bench for ahb_mbox_ctrl: directed handshake scenarios followed by random bus
// traffic, every cycle compared against a transaction-level mailbox model.
module tb_ahb_mbox_ctrl;

   localparam int M_IDLE  = 0;
   localparam int M_FULL  = 1;
   localparam int M_ACKED = 2;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [31:0] hwdata;
   logic [1:0]  hresp;
   logic        hready;
   logic [31:0] hrdata;
   logic        intr_a;
   logic        intr_b;

   ahb_mbox_ctrl dut (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr),
      .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata), .hresp(hresp),
      .hready(hready), .hrdata(hrdata), .intr_a(intr_a), .intr_b(intr_b)
   );

   always #5 hclk = ~hclk;

   typedef struct {
      int st;
      bit rx, ack, err, tmo;
      int size, id, elapsed;
   } mch_t;

   mch_t        m [2];
   int          m_lim;
   logic [31:0] exp_hrdata;
   logic        exp_ia, exp_ib;
   logic        pend_v;
   logic [7:0]  pend_a;
   logic [31:0] pend_data;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  addr_tab [12];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] a);
      int c;
      if (a == 8'h04 || a == 8'h14) begin
         c = (a == 8'h14) ? 1 : 0;
         return {m[c].rx, (m[c].st == M_FULL), m[c].ack, m[c].err, m[c].tmo,
                 4'b0000, 15'(m[c].size), 8'(m[c].id)};
      end
      if (a == 8'h20) return 32'(m_lim);
      return 32'h0000_0000;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) m[c] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
      m_lim = 0; exp_hrdata = 32'h0; exp_ia = 1'b0; exp_ib = 1'b0;
      pend_v = 1'b0; pend_a = 8'h00; pend_data = 32'h0;
   endtask

   // One clock edge of the mailbox rules: read capture, then pending write data phase
   task automatic model_edge(input bit v, input bit w, input logic [7:0] a);
      mch_t o, n;
      bit post, ack, clr, eset, tset;
      int lim_old = m_lim;
      logic [31:0] d = pend_data;
      if (v && !w) exp_hrdata = model_read(a);
      exp_ib = m[0].rx | m[1].ack;
      exp_ia = m[1].rx | m[0].ack;
      for (int c = 0; c < 2; c++) begin
         o = m[c]; n = m[c];
         post = pend_v && (pend_a == 8'(16 * c));
         ack  = pend_v && (pend_a == 8'(16 * c + 8));
         clr  = pend_v && (pend_a == 8'(16 * c + 12));
         eset = 1'b0; tset = 1'b0;
         if (o.st == M_FULL && lim_old != 0) n.elapsed = o.elapsed + 1;
         if (post) begin
            if (o.st == M_IDLE) begin
               n.st = M_FULL; n.size = int'(d[22:8]); n.id = int'(d[7:0]);
               n.rx = 1'b1; n.elapsed = 0;
            end else eset = 1'b1;
         end
         if (ack) begin
            if (o.st == M_FULL) begin n.st = M_ACKED; n.rx = 1'b0; n.ack = 1'b1; end
            else eset = 1'b1;
         end
         if (clr && d[0]) begin
            if (o.st == M_FULL) eset = 1'b1;
            else begin n.st = M_IDLE; n.ack = 1'b0; end
         end
         if (o.st == M_FULL && !ack && lim_old != 0 && o.elapsed + 1 >= lim_old) begin
            n.st = M_IDLE; n.rx = 1'b0; n.ack = 1'b1; tset = 1'b1;
         end
         n.err = eset ? 1'b1 : ((clr && d[1]) ? 1'b0 : o.err);
         n.tmo = tset ? 1'b1 : ((clr && d[2]) ? 1'b0 : o.tmo);
         m[c] = n;
      end
      if (pend_v && pend_a == 8'h20) m_lim = int'(d[15:0]);
   endtask

   // Drive one address phase (plus the previous write's data) and check outputs after the edge
   task automatic bus(input bit v, input bit w, input logic [7:0] a, input logic [31:0] d);
      hsel = v; htrans = v ? 2'b10 : 2'b00; hwrite = w;
      haddr = {24'h000000, a}; hwdata = pend_data;
      model_edge(v, w, a);
      pend_v = v && w; pend_a = a; pend_data = d;
      @(negedge hclk);
      check_val("hrdata", hrdata, exp_hrdata);
      check_val("intr_a", {31'h0, intr_a}, {31'h0, exp_ia});
      check_val("intr_b", {31'h0, intr_b}, {31'h0, exp_ib});
      check_val("hresp_hready", {29'h0, hresp, hready}, 32'h0000_0001);
   endtask

   task automatic idle();                                 bus(1'b0, 1'b0, 8'h00, 32'h0); endtask
   task automatic wr(input logic [7:0] a, input logic [31:0] d); bus(1'b1, 1'b1, a, d); endtask
   task automatic rd(input logic [7:0] a);                bus(1'b1, 1'b0, a, 32'h0); endtask

   task automatic do_reset();
      @(posedge hclk);
      #2 hresetn = 1'b0;
      #1;
      check_val("rst_async_hrdata", hrdata, 32'h0);
      check_val("rst_async_intr", {30'h0, intr_a, intr_b}, 32'h0);
      model_reset();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      @(negedge hclk);
      hresetn = 1'b1;
   endtask

   initial begin
      logic [7:0] a;
      logic [31:0] d;
      bit v, w;
      addr_tab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                   8'h20, 8'h24, 8'h30, 8'h02};
      model_reset();
      hresetn = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      haddr = 32'h0; hwdata = 32'h0;
      #1;
      check_val("rst_hrdata", hrdata, 32'h0);
      check_val("rst_intr", {30'h0, intr_a, intr_b}, 32'h0);
      repeat (2) @(negedge hclk);
      hresetn = 1'b1;

      // POST on CH0, interrupt one cycle after the data phase
      wr(8'h00, 32'h0000_4212); idle();
      check_val("t1_intr_b_early", {31'h0, intr_b}, 32'h0);
      rd(8'h04);
      check_val("t1_stat", hrdata, 32'hC000_4212);
      check_val("t1_intr", {30'h0, intr_a, intr_b}, 32'h1);

      // ACK then CLR.bit0
      wr(8'h08, 32'h0); idle(); idle(); rd(8'h04);
      check_val("t2_stat_acked", hrdata, 32'h2000_4212);
      check_val("t2_intr", {30'h0, intr_a, intr_b}, 32'h2);
      wr(8'h0C, 32'h1); idle(); idle(); rd(8'h04);
      check_val("t2_stat_clr", hrdata, 32'h0000_4212);
      check_val("t2_intr_a", {31'h0, intr_a}, 32'h0);

      // Illegal second POST, then clear err
      wr(8'h00, 32'h0000_4212); wr(8'h00, 32'h0000_7733); idle(); rd(8'h04);
      check_val("t3_stat_err", hrdata, 32'hD000_4212);
      wr(8'h0C, 32'h2); idle(); rd(8'h04);
      check_val("t3_stat_noerr", hrdata, 32'hC000_4212);
      wr(8'h08, 32'h0); wr(8'h0C, 32'h1); idle();

      // Timeout on CH1 with limit 5, then ACK racing the firing edge
      wr(8'h20, 32'h5); wr(8'h10, 32'h0000_0155); idle();
      repeat (4) idle();
      rd(8'h14);
      check_val("t4_still_full", {27'h0, hrdata[31:27]}, 32'h18);
      rd(8'h14);
      check_val("t4_timed_out", {27'h0, hrdata[31:27]}, 32'h05);
      check_val("t4_intr", {30'h0, intr_a, intr_b}, 32'h1);
      wr(8'h1C, 32'h5); idle();
      wr(8'h10, 32'h0000_0266); idle();
      repeat (3) idle();
      wr(8'h18, 32'h0); idle(); rd(8'h14);
      check_val("t4_ack_wins", {27'h0, hrdata[31:27]}, 32'h04);
      wr(8'h1C, 32'h1); idle();

      // Both channels posted back to back
      wr(8'h20, 32'h0);
      wr(8'h00, 32'h0000_0101); wr(8'h10, 32'h0000_0202); idle(); idle();
      check_val("t5_both", {30'h0, intr_a, intr_b}, 32'h3);
      wr(8'h08, 32'h0); idle(); idle();
      check_val("t5_ack_ch0", {30'h0, intr_a, intr_b}, 32'h2);
      wr(8'h18, 32'h0); wr(8'h0C, 32'h1); wr(8'h1C, 32'h1); idle();

      // Reset while CH0 is FULL with counter 3
      wr(8'h20, 32'd20); wr(8'h00, 32'h0000_0333); idle();
      repeat (3) idle();
      do_reset();
      rd(8'h04);
      check_val("t6_stat_zero", hrdata, 32'h0);
      rd(8'h20);
      check_val("t6_lim_zero", hrdata, 32'h0);
      wr(8'h00, 32'h0000_0444); idle(); rd(8'h04);
      check_val("t6_repost", hrdata, 32'hC000_0444);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         v = ($urandom_range(0, 3) != 0);
         w = ($urandom_range(0, 1) != 0);
         a = addr_tab[$urandom_range(0, 11)];
         if (a == 8'h20)                   d = $urandom_range(0, 8);
         else if (a == 8'h0C || a == 8'h1C) d = $urandom_range(0, 7);
         else                              d = $urandom;
         bus(v, w, a, d);
      end
      idle(); idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
